// File: rtl/lte_ul_pwr_pkg.sv
// Shared types and widths for the uplink per-antenna power meter.
package lte_ul_pwr_pkg;

  localparam int IQ_W       = 15;
  localparam int PWR_W      = 2 * IQ_W;
  localparam int PIPE_DEPTH = 4;

  // IDLE wait start | ARM wait frame head | ACCUM sum | DRAIN flush pipe | DUMP emit beats
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    DUMP  = 3'd4
  } state_e;

endpackage

// File: rtl/lte_ul_pwr_sq.sv
// Three-stage power pipeline: register I/Q, square each, sum to I^2+Q^2.
// A slot tag rides alongside so the accumulator knows which antenna to update.
module lte_ul_pwr_sq
  import lte_ul_pwr_pkg::*;
#(
  parameter int TAG_W = 3
) (
  input  logic             clk_245,
  input  logic             syn_rst,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [PWR_W-1:0] data_i,
  output logic             valid_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [PWR_W-1:0] sum_o
);

  logic signed [IQ_W-1:0]  i_q, q_q;
  logic signed [PWR_W-1:0] i_ext, q_ext;
  logic [PWR_W-1:0]        isq_d, qsq_d, isq_q, qsq_q, sum_q;
  logic [2:0]              vld_q;
  logic [TAG_W-1:0]        tag1_q, tag2_q, tag3_q;

  always_comb begin
    i_ext = {{IQ_W{i_q[IQ_W-1]}}, i_q};
    q_ext = {{IQ_W{q_q[IQ_W-1]}}, q_q};
    isq_d = $unsigned(i_ext * i_ext);
    qsq_d = $unsigned(q_ext * q_ext);
  end

  // A flush kills samples already past the input register; the new one still enters.
  always_ff @(posedge clk_245) begin
    if (syn_rst) begin
      vld_q  <= '0;
      i_q    <= '0;
      q_q    <= '0;
      isq_q  <= '0;
      qsq_q  <= '0;
      sum_q  <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
    end else begin
      vld_q  <= {vld_q[1] & ~flush_i, vld_q[0] & ~flush_i, valid_i};
      i_q    <= data_i[PWR_W-1:IQ_W];
      q_q    <= data_i[IQ_W-1:0];
      isq_q  <= isq_d;
      qsq_q  <= qsq_d;
      sum_q  <= isq_q + qsq_q;
      tag1_q <= tag_i;
      tag2_q <= tag1_q;
      tag3_q <= tag2_q;
    end
  end

  assign valid_o = vld_q[2];
  assign tag_o   = tag3_q;
  assign sum_o   = sum_q;

endmodule

// File: rtl/lte_ul_ant_pwr_meas.sv
// Per-antenna uplink power meter: averages I^2+Q^2 over a TDM antenna stream
// and streams one mean-power beat per antenna through a valid/ready port.
module lte_ul_ant_pwr_meas
  import lte_ul_pwr_pkg::*;
#(
  parameter int XNUM     = 8,
  parameter int WIN_LOG2 = 10
) (
  input  logic             clk_245,
  input  logic             syn_rst,
  input  logic [PWR_W-1:0] i_data,
  input  logic             i_data_valid,
  input  logic             i_fram_hd,
  input  logic             i_ant8_sel,
  input  logic             i_meas_start,
  input  logic             i_pwr_ready,
  output logic             o_pwr_valid,
  output logic [2:0]       o_pwr_ant,
  output logic [PWR_W-1:0] o_pwr,
  output logic             o_busy,
  output logic             o_sync_err
);

  localparam int ACC_W = PWR_W + WIN_LOG2;
  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((1 << WIN_LOG2) - 1);
  localparam logic [1:0]       DRAIN_LAST = 2'(PIPE_DEPTH - 1);

  state_e           state_q, state_d;
  logic [2:0]       slot_q, dump_q, in_slot, nant_m1, sq_tag;
  logic [1:0]       drain_q;
  logic             ant8_q, sync_err_q;
  logic [CNT_W-1:0] cnt_q [XNUM];
  logic [ACC_W-1:0] acc_q [XNUM];
  logic             start, take_first, in_accum, resync, accept;
  logic             win_clear, win_done, dump_last, sq_valid;
  logic [PWR_W-1:0] sq_sum;

  assign nant_m1 = ant8_q ? 3'd7 : 3'd3;

  always_comb begin
    start      = (state_q == IDLE) && i_meas_start;
    take_first = (state_q == ARM) && i_data_valid && i_fram_hd;
    in_accum   = (state_q == ACCUM) && i_data_valid;
    resync     = in_accum && i_fram_hd && (slot_q != 3'd0);
    accept     = take_first || in_accum;
    in_slot    = resync ? 3'd0 : slot_q;
    win_clear  = start || resync;
    win_done   = in_accum && !resync && (slot_q == nant_m1) && (cnt_q[slot_q] == CNT_LAST);
    dump_last  = (state_q == DUMP) && i_pwr_ready && (dump_q == nant_m1);
  end

  always_ff @(posedge clk_245) begin
    if (syn_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_meas_start)   state_d = ARM;
      ARM:     if (take_first)     state_d = ACCUM;
      ACCUM:   if (win_done)       state_d = DRAIN;
      DRAIN:   if (drain_q == '0)  state_d = DUMP;
      DUMP:    if (dump_last)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_245) begin
    if (syn_rst) begin
      slot_q     <= '0;
      dump_q     <= '0;
      drain_q    <= '0;
      ant8_q     <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      if (start)       slot_q <= '0;
      else if (accept) slot_q <= (in_slot == nant_m1) ? 3'd0 : in_slot + 3'd1;
      if (start)       sync_err_q <= 1'b0;
      else if (resync) sync_err_q <= 1'b1;
      if (take_first)  ant8_q <= i_ant8_sel;
      if (win_done)                                drain_q <= DRAIN_LAST;
      else if (state_q == DRAIN && drain_q != '0)  drain_q <= drain_q - 2'd1;
      if (state_q != DUMP)                         dump_q <= '0;
      else if (i_pwr_ready && !dump_last)          dump_q <= dump_q + 3'd1;
    end
  end

  // A frame-head resync restarts the window with the current sample already counted as slot 0.
  always_ff @(posedge clk_245) begin
    if (syn_rst || win_clear) begin
      for (int k = 0; k < XNUM; k++) begin
        acc_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      if (!syn_rst && resync) cnt_q[0] <= CNT_W'(1);
    end else begin
      if (sq_valid) acc_q[sq_tag] <= acc_q[sq_tag] + ACC_W'(sq_sum);
      if (accept)   cnt_q[in_slot] <= cnt_q[in_slot] + CNT_W'(1);
    end
  end

  lte_ul_pwr_sq #(.TAG_W(3)) u_sq (
    .clk_245 (clk_245),
    .syn_rst (syn_rst),
    .flush_i (resync),
    .valid_i (accept),
    .tag_i   (in_slot),
    .data_i  (i_data),
    .valid_o (sq_valid),
    .tag_o   (sq_tag),
    .sum_o   (sq_sum)
  );

  always_comb begin
    o_busy      = (state_q != IDLE);
    o_sync_err  = sync_err_q;
    o_pwr_valid = 1'b0;
    o_pwr_ant   = '0;
    o_pwr       = '0;
    if (state_q == DUMP) begin
      o_pwr_valid = 1'b1;
      o_pwr_ant   = dump_q;
      o_pwr       = acc_q[dump_q][ACC_W-1:WIN_LOG2];
    end
  end

endmodule

// File: tb/tb_lte_ul_ant_pwr_meas.sv
// Scoreboard bench for the per-antenna power meter: a plain-arithmetic model
// sums I^2+Q^2 per antenna and queues the expected beats for the monitor.
module tb_lte_ul_ant_pwr_meas;

  localparam int WIN   = 4;
  localparam int NSAMP = 1 << WIN;

  logic        clk_245 = 1'b0;
  logic        syn_rst;
  logic [29:0] i_data;
  logic        i_data_valid, i_fram_hd, i_ant8_sel, i_meas_start, i_pwr_ready;
  logic        o_pwr_valid, o_busy, o_sync_err;
  logic [2:0]  o_pwr_ant;
  logic [29:0] o_pwr;

  typedef struct {
    int     ant;
    longint pwr;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    ready_mode = 0;

  lte_ul_ant_pwr_meas #(.XNUM(8), .WIN_LOG2(WIN)) dut (
    .clk_245      (clk_245),
    .syn_rst      (syn_rst),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .i_fram_hd    (i_fram_hd),
    .i_ant8_sel   (i_ant8_sel),
    .i_meas_start (i_meas_start),
    .i_pwr_ready  (i_pwr_ready),
    .o_pwr_valid  (o_pwr_valid),
    .o_pwr_ant    (o_pwr_ant),
    .o_pwr        (o_pwr),
    .o_busy       (o_busy),
    .o_sync_err   (o_sync_err)
  );

  initial forever #2 clk_245 = ~clk_245;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic int rnd15();
    return int'($urandom_range(0, 32767)) - 16384;
  endfunction

  task automatic gen_iq(input int pat, input int s, output int iv, output int qv);
    case (pat)
      0:       begin iv = 1000;    qv = 0;      end
      1:       begin iv = 100 * s; qv = 100 * s; end
      2:       begin iv = -16384;  qv = -16384; end
      default: begin iv = rnd15(); qv = rnd15(); end
    endcase
  endtask

  // Random idle gaps carry a stray frame head with valid low, which must be ignored.
  task automatic drive_sample(input int iv, input int qv, input bit hd, input bit poke_start);
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 2)) begin
        i_data_valid = 1'b0;
        i_fram_hd    = 1'($urandom_range(0, 1));
        i_data       = 30'($urandom);
        @(posedge clk_245); #1;
      end
    end
    i_data       = {15'(iv), 15'(qv)};
    i_data_valid = 1'b1;
    i_fram_hd    = hd;
    i_meas_start = poke_start;
    @(posedge clk_245); #1;
    i_data_valid = 1'b0;
    i_fram_hd    = 1'b0;
    i_meas_start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, o_pwr_valid, 0);
    check({tag, "_pwr"},   o_pwr,       0);
    check({tag, "_ant"},   o_pwr_ant,   0);
  endtask

  task automatic run_window(input bit ant8, input int pat, input bit do_resync, input int rmode);
    int     nant, iv, qv, waited;
    longint acc[8];
    nant = ant8 ? 8 : 4;
    foreach (acc[k]) acc[k] = 0;
    ready_mode   = rmode;
    i_ant8_sel   = ant8;
    i_meas_start = 1'b1;
    @(posedge clk_245); #1;
    i_meas_start = 1'b0;
    check("busy_after_start", o_busy, 1);
    check("sync_err_cleared", o_sync_err, 0);
    for (int k = 0; k < 2; k++) drive_sample(rnd15(), rnd15(), 1'b0, 1'b0);
    if (do_resync) begin
      for (int s = 0; s < nant; s++) drive_sample(rnd15(), rnd15(), s == 0, 1'b0);
      for (int s = 0; s < 3; s++)    drive_sample(rnd15(), rnd15(), s == 0, 1'b0);
    end
    for (int r = 0; r < NSAMP; r++) begin
      for (int s = 0; s < nant; s++) begin
        gen_iq(pat, s, iv, qv);
        acc[s] += longint'(iv) * iv + longint'(qv) * qv;
        drive_sample(iv, qv, s == 0, (r == 5) && (s == 1));
        i_ant8_sel = 1'($urandom_range(0, 1));
      end
    end
    for (int s = 0; s < nant; s++) exp_q.push_back('{ant: s, pwr: acc[s] >> WIN});
    for (int k = 0; k < 3; k++) drive_sample(rnd15(), rnd15(), 1'($urandom_range(0, 1)), 1'b0);
    waited = 0;
    while (o_busy && waited < 3000) begin
      @(posedge clk_245); #1;
      waited++;
    end
    check("window_done_busy", o_busy, 0);
    check("beats_outstanding", exp_q.size(), 0);
    exp_q.delete();
    check("sync_err_flag", o_sync_err, do_resync);
    check_idle_outputs("idle");
  endtask

  initial begin
    bit       prev_hold = 1'b0;
    logic [2:0]  prev_ant = '0;
    logic [29:0] prev_pwr = '0;
    beat_t    e;
    forever begin
      @(negedge clk_245);
      if (syn_rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", o_pwr_valid, 1);
          check("hold_ant",   o_pwr_ant,   prev_ant);
          check("hold_pwr",   o_pwr,       prev_pwr);
        end
        if (o_pwr_valid && i_pwr_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: got ant %0d pwr %0d, expected no beat", o_pwr_ant, o_pwr);
          end else begin
            e = exp_q.pop_front();
            check("beat_ant", o_pwr_ant, e.ant);
            check("beat_pwr", o_pwr,     e.pwr);
          end
        end
        prev_hold = o_pwr_valid && !i_pwr_ready;
        prev_ant  = o_pwr_ant;
        prev_pwr  = o_pwr;
      end
    end
  end

  // Mode 0: always ready; 1: random; 2: stall five cycles on the first antenna-2 beat.
  initial begin
    int hold_cnt = 0;
    bit held     = 1'b0;
    i_pwr_ready = 1'b1;
    forever begin
      @(posedge clk_245); #1;
      if (!o_busy) held = 1'b0;
      case (ready_mode)
        0: i_pwr_ready = 1'b1;
        1: i_pwr_ready = 1'($urandom_range(0, 1));
        default: begin
          if (hold_cnt > 0) begin
            i_pwr_ready = 1'b0;
            hold_cnt--;
          end else if (o_pwr_valid && o_pwr_ant == 3'd2 && !held) begin
            i_pwr_ready = 1'b0;
            hold_cnt    = 4;
            held        = 1'b1;
          end else begin
            i_pwr_ready = 1'b1;
          end
        end
      endcase
    end
  end

  initial begin
    syn_rst      = 1'b1;
    i_data       = '0;
    i_data_valid = 1'b0;
    i_fram_hd    = 1'b0;
    i_ant8_sel   = 1'b0;
    i_meas_start = 1'b0;
    repeat (3) @(posedge clk_245);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_sync_err", o_sync_err, 0);
    check_idle_outputs("rst");
    syn_rst = 1'b0;

    run_window(1'b1, 0, 1'b0, 0);
    run_window(1'b1, 1, 1'b0, 2);
    run_window(1'b0, 2, 1'b0, 1);
    run_window(1'b1, 1, 1'b1, 1);
    run_window(1'b0, 3, 1'b1, 0);

    ready_mode   = 1;
    i_ant8_sel   = 1'b1;
    i_meas_start = 1'b1;
    @(posedge clk_245); #1;
    i_meas_start = 1'b0;
    for (int s = 0; s < 8; s++)  drive_sample(rnd15(), rnd15(), s == 0, 1'b0);
    for (int s = 0; s < 3; s++)  drive_sample(rnd15(), rnd15(), s == 0, 1'b0);
    for (int k = 0; k < 20; k++) drive_sample(rnd15(), rnd15(), (k % 8) == 0, 1'b0);
    check("abort_sync_err", o_sync_err, 1);
    check("abort_busy", o_busy, 1);
    syn_rst = 1'b1;
    @(posedge clk_245); #1;
    check("abort_rst_busy", o_busy, 0);
    check("abort_rst_sync_err", o_sync_err, 0);
    check_idle_outputs("abort_rst");
    syn_rst = 1'b0;
    run_window(1'b1, 3, 1'b0, 1);

    for (int w = 0; w < 4; w++)
      run_window(1'($urandom_range(0, 1)), 3, 1'($urandom_range(0, 1)), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lte_ul_ant_pwr_meas.md
LTE_UL_ANT_PWR_MEAS -- requirements
Module: lte_ul_ant_pwr_meas

Interface
REQ-001 Parameters SHALL be XNUM, 8, maximum antennas in the TDM stream.
REQ-002 Parameters SHALL be WIN_LOG2, 10, log2 of samples averaged per antenna.
REQ-003 Ports SHALL be clk_245  in  1  sole clock; all logic on rising edge.
REQ-004 Ports SHALL be syn_rst  in  1  reset, synchronous and active-high.
REQ-005 Ports SHALL be i_data  in  30  AGC output {I[29:15], Q[14:0]}, two's complement.
REQ-006 Ports SHALL be i_data_valid  in  1  i_data qualifier.
REQ-007 Ports SHALL be i_fram_hd  in  1  frame head; marks the antenna-0 sample.
REQ-008 Ports SHALL be i_ant8_sel  in  1  1 = 8 antennas in TDM, 0 = 4 antennas.
REQ-009 Ports SHALL be i_meas_start  in  1  single-cycle request for one measurement window.
REQ-010 Ports SHALL be i_pwr_ready  in  1  consumer ready for a result beat.
REQ-011 Ports SHALL be o_pwr_valid  out  1  result beat valid.
REQ-012 Ports SHALL be o_pwr_ant  out  3  antenna index of the beat.
REQ-013 Ports SHALL be o_pwr  out  30  mean I^2+Q^2 for that antenna.
REQ-014 Ports SHALL be o_busy  out  1  high in any state other than IDLE.
REQ-015 Ports SHALL be o_sync_err  out  1  sticky; cleared only by syn_rst or i_meas_start.

Function
REQ-016 The FSM SHALL have states IDLE, ARM, ACCUM, DRAIN and DUMP.
REQ-017 IDLE->ARM on i_meas_start; the accumulators, per-slot counts and o_sync_err SHALL clear; i_meas_start is ignored outside IDLE.
REQ-018 ARM->ACCUM on the first cycle with i_fram_hd=1 and i_data_valid=1; that sample SHALL be accumulated as slot 0.
REQ-019 Slot counter SHALL advance only on valid samples and wrap at NANT-1 to 0, where NANT is 8 if i_ant8_sel=1, else 4.
REQ-020 i_ant8_sel SHALL be latched at ARM->ACCUM and held for the window.
REQ-021 Datapath SHALL be: register I/Q; square each to 30-bit unsigned; sum to 30-bit; add into slot accumulator of width 30+WIN_LOG2; no truncation, no saturation.
REQ-022 Valid-to-accumulator update latency SHALL be 4 cycles; back-to-back valids SHALL be accepted on every cycle.
REQ-023 Window completion SHALL occur when slot NANT-1 has received 2^WIN_LOG2 samples; ACCUM->DRAIN then.
REQ-024 DRAIN SHALL last 4 cycles to flush the pipeline; inputs are ignored from DRAIN onward.
REQ-025 In DUMP, the block SHALL present slots 0..NANT-1 in order with o_pwr = acc >> WIN_LOG2.
REQ-026 A beat SHALL transfer when o_pwr_valid & i_pwr_ready; o_pwr, o_pwr_ant and o_pwr_valid SHALL remain stable while i_pwr_ready=0.
REQ-027 After the NANT-1 beat transfers, the FSM SHALL return to IDLE on the next cycle.
REQ-028 i_fram_hd valid in ACCUM with slot counter != 0 SHALL set o_sync_err, clear the accumulators and counts, and restart the window with that sample as slot 0.
REQ-029 i_fram_hd with i_data_valid=0 SHALL be ignored.
REQ-030 o_pwr_valid SHALL be 0 outside DUMP; o_pwr and o_pwr_ant SHALL be 0 outside DUMP.

Reset
REQ-031 syn_rst SHALL force IDLE and zero all outputs, accumulators, counters and pipeline registers on the next edge.
REQ-032 syn_rst SHALL take priority over every other input.
REQ-033 syn_rst in any state, including mid-DUMP, SHALL abandon the window; no partial beats are emitted.

Structure
REQ-034 Package lte_ul_pwr_pkg SHALL hold the FSM state enum, the I/Q width (15) and the pipeline depth (4).
REQ-035 Sub-module lte_ul_pwr_sq SHALL implement the 3-stage register/square/sum pipeline; the top holds the FSM, the counters and the accumulator array.

Verification (WIN_LOG2=4)
REQ-036 8-ant, every sample I=1000, Q=0 -> 8 beats, ant 0..7, o_pwr=1000000 each.
REQ-037 8-ant, antenna k I=Q=100*k -> o_pwr=20000*k^2, e.g. ant7=980000.
REQ-038 4-ant, I=-16384, Q=-16384 -> 4 beats, o_pwr=536870912, o_pwr_ant 0..3.
REQ-039 i_pwr_ready low 5 cycles at ant 2 -> o_pwr and o_pwr_ant held; no beat lost or duplicated.
REQ-040 i_fram_hd at slot 3 mid-ACCUM -> o_sync_err=1; the restarted window still yields exact results.
REQ-041 syn_rst mid-ACCUM, then i_meas_start -> IDLE, all outputs 0; the fresh window is unaffected by stale sums.
